// File: rtl/downsampler2x_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// downsampler2x_pkg : shared pyramid constants and the 2x2 rounding average
// Revision: 1.0
// ---------------------------------------------------------------------------
package downsampler2x_pkg;

    localparam int DEFAULT_NUMCOL = 800;
    localparam int DEFAULT_NUMROW = 600;
    localparam int PIX_W          = 8;
    localparam int CNT_W          = 10;
    localparam int HSUM_W         = PIX_W + 1;
    localparam int VSUM_W         = PIX_W + 2;

    // Four 8-bit samples sum to at most 1020, so +2 cannot overflow VSUM_W bits.
    function automatic logic [PIX_W-1:0] round_avg(input logic [VSUM_W-1:0] sum);
        return PIX_W'((sum + VSUM_W'(2)) >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pair_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pair_line_buffer : simple dual-port RAM of horizontal pair sums, registered read
// Revision: 1.0
// ---------------------------------------------------------------------------
module pair_line_buffer #(
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset: odd rows only ever read entries written by the preceding even row.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/downsampler2x.sv
`default_nettype none
// ---------------------------------------------------------------------------
// downsampler2x : raster stream to half-resolution stream via rounded 2x2 box average
// Revision: 1.0
// ---------------------------------------------------------------------------
module downsampler2x
    import downsampler2x_pkg::*;
#(
    parameter int NUMCOL = DEFAULT_NUMCOL,
    parameter int NUMROW = DEFAULT_NUMROW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [7:0]       data,
    output logic [7:0]       dataout,
    output logic             validout,
    output logic [9:0]       out_colcount,
    output logic [9:0]       out_rowcount,
    output logic             frame_done
);

    localparam int              DEPTH    = NUMCOL / 2;
    localparam int              ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(NUMCOL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(NUMROW - 1);

    if ((NUMCOL % 2) != 0 || NUMCOL < 2 || NUMCOL > 1024) begin : g_bad_numcol
        $error("downsampler2x: NUMCOL must be even and in 2..1024");
    end
    if ((NUMROW % 2) != 0 || NUMROW < 2 || NUMROW > 1024) begin : g_bad_numrow
        $error("downsampler2x: NUMROW must be even and in 2..1024");
    end

    logic [CNT_W-1:0]  colcount_q, colcount_d;
    logic [CNT_W-1:0]  rowcount_q, rowcount_d;
    logic [PIX_W-1:0]  hold_px_q;
    logic [PIX_W-1:0]  dataout_q;
    logic              validout_q;
    logic [CNT_W-1:0]  out_colcount_q;
    logic [CNT_W-1:0]  out_rowcount_q;
    logic              frame_done_q;

    logic              w_rd_en;
    logic              w_wr_en;
    logic              w_out_en;
    logic [ADDR_W-1:0] w_addr;
    logic [HSUM_W-1:0] w_hsum;
    logic [HSUM_W-1:0] w_linebuf_q;
    logic [VSUM_W-1:0] w_vsum;

    assign w_rd_en  = valid & ~colcount_q[0] &  rowcount_q[0];
    assign w_wr_en  = valid &  colcount_q[0] & ~rowcount_q[0];
    assign w_out_en = valid &  colcount_q[0] &  rowcount_q[0];
    assign w_addr   = colcount_q[ADDR_W:1];
    assign w_hsum   = {1'b0, hold_px_q} + {1'b0, data};
    assign w_vsum   = {1'b0, w_linebuf_q} + {1'b0, w_hsum};

    always_comb begin
        colcount_d = colcount_q;
        rowcount_d = rowcount_q;
        if (valid) begin
            if (colcount_q == COL_LAST) begin
                colcount_d = '0;
                rowcount_d = (rowcount_q == ROW_LAST) ? '0 : rowcount_q + 1'b1;
            end else begin
                colcount_d = colcount_q + 1'b1;
            end
        end
    end

    pair_line_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (HSUM_W)
    ) u_linebuf (
        .clock   (clock),
        .we_i    (w_wr_en),
        .waddr_i (w_addr),
        .wdata_i (w_hsum),
        .re_i    (w_rd_en),
        .raddr_i (w_addr),
        .rdata_o (w_linebuf_q)
    );

    // Output position is the source block position, so it tracks the input counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            colcount_q     <= '0;
            rowcount_q     <= '0;
            hold_px_q      <= '0;
            dataout_q      <= '0;
            validout_q     <= 1'b0;
            out_colcount_q <= '0;
            out_rowcount_q <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            colcount_q   <= colcount_d;
            rowcount_q   <= rowcount_d;
            validout_q   <= w_out_en;
            frame_done_q <= w_out_en && (colcount_q == COL_LAST) && (rowcount_q == ROW_LAST);
            if (valid && !colcount_q[0]) begin
                hold_px_q <= data;
            end
            if (w_out_en) begin
                dataout_q      <= round_avg(w_vsum);
                out_colcount_q <= {1'b0, colcount_q[CNT_W-1:1]};
                out_rowcount_q <= {1'b0, rowcount_q[CNT_W-1:1]};
            end
        end
    end

    assign dataout      = dataout_q;
    assign validout     = validout_q;
    assign out_colcount = out_colcount_q;
    assign out_rowcount = out_rowcount_q;
    assign frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_downsampler2x.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_downsampler2x : directed + randomized bench against a whole-frame box-average model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_downsampler2x;

    localparam int NCOL = 8;
    localparam int NROW = 4;

    logic       clock;
    logic       reset_n;
    logic       valid;
    logic [7:0] data;
    logic [7:0] dataout;
    logic       validout;
    logic [9:0] out_colcount;
    logic [9:0] out_rowcount;
    logic       frame_done;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_count = 0;

    logic [7:0] img [NROW][NCOL];

    downsampler2x #(
        .NUMCOL (NCOL),
        .NUMROW (NROW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid        (valid),
        .data         (data),
        .dataout      (dataout),
        .validout     (validout),
        .out_colcount (out_colcount),
        .out_rowcount (out_rowcount),
        .frame_done   (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given input; outputs are checked 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input bit ev,
                        input int ed, input int ec, input int er, input bit efd);
        valid = v;
        data  = d;
        @(posedge clock);
        #1;
        check("validout", validout, 32'(ev));
        check("frame_done", frame_done, 32'(efd));
        if (frame_done === 1'b1) fd_count++;
        if (ev) begin
            check("dataout", dataout, ed);
            check("out_colcount", out_colcount, ec);
            check("out_rowcount", out_rowcount, er);
        end
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), 1'b0, 0, 0, 0, 1'b0);
    endtask

    function automatic int box_avg(input int r, input int c);
        int s;
        s = int'(img[r-1][c-1]) + int'(img[r-1][c]) + int'(img[r][c-1]) + int'(img[r][c]);
        return (s + 2) / 4;
    endfunction

    // Streams the image in raster order; stops before pixel index stop_at.
    task automatic stream_frame(input bit gapped, input int stop_at);
        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) begin
                bit ev;
                int gaps;
                if (r * NCOL + c == stop_at) return;
                ev = (r % 2 == 1) && (c % 2 == 1);
                step(1'b1, img[r][c], ev, ev ? box_avg(r, c) : 0, c / 2, r / 2,
                     ev && (c == NCOL - 1) && (r == NROW - 1));
                if (gapped) begin
                    gaps = (r == 1 && c == 0) ? 2 : 0;
                    for (int k = 0; k < gaps; k++) idle();
                    for (int k = 0; k < 8 && $urandom_range(0, 99) >= 30; k++) idle();
                end
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) img[r][c] = 8'(v);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) img[r][c] = 8'(c + 16 * r);
    endtask

    task automatic fill_random();
        for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++) img[r][c] = 8'($urandom);
    endtask

    task automatic fill_rounding();
        fill_random();
        img[0][0] = 8'd1;   img[0][1] = 8'd2;   img[1][0] = 8'd3;   img[1][1] = 8'd4;
        img[0][2] = 8'd0;   img[0][3] = 8'd0;   img[1][2] = 8'd0;   img[1][3] = 8'd1;
        img[0][4] = 8'd0;   img[0][5] = 8'd0;   img[1][4] = 8'd1;   img[1][5] = 8'd1;
        img[0][6] = 8'd255; img[0][7] = 8'd255; img[1][6] = 8'd255; img[1][7] = 8'd255;
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_dataout", dataout, 0);
        check("reset_validout", validout, 0);
        check("reset_out_colcount", out_colcount, 0);
        check("reset_out_rowcount", out_rowcount, 0);
        check("reset_frame_done", frame_done, 0);
        reset_n = 1'b1;

        // Rounding corner cases: 3, 0, 1, 255 in the first output row.
        fill_rounding();
        stream_frame(1'b0, -1);
        idle();

        fill_ramp();
        stream_frame(1'b0, -1);
        idle();

        // Same ramp with sparse valid, including forced gaps inside a pair.
        stream_frame(1'b1, -1);

        // Two frames back to back with no idle cycles in between.
        fd_count = 0;
        fill_const(100);
        stream_frame(1'b0, -1);
        fill_random();
        stream_frame(1'b0, -1);
        check("frame_done_count", fd_count, 2);
        idle();

        // Abort a frame at row 3, col 5 with an asynchronous reset.
        fill_random();
        stream_frame(1'b0, 3 * NCOL + 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_dataout", dataout, 0);
        check("async_validout", validout, 0);
        check("async_out_colcount", out_colcount, 0);
        check("async_out_rowcount", out_rowcount, 0);
        check("async_frame_done", frame_done, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        fill_random();
        stream_frame(1'b1, -1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/downsampler2x.md
# downsampler2x

- Converts a raster pixel stream of NUMCOL×NUMROW 8-bit samples into a half-resolution stream.
- Each output pixel is the rounded 2×2 box average of its source block, so a 400×300 image is produced from 800×600.
- Sits at the input of each scale-space pyramid level, ahead of the feature filters. It is the counterpart of the 2× row/column upsampler.
- The input has no backpressure, and the output rate is at most 1/4 of the input rate, so the output has no backpressure either.

## Interface
Parameters:
- NUMCOL, 800, input pixels per row; must be even, ≤1024.
- NUMROW, 600, input rows per frame; must be even, ≤1024.

Ports:
- clock  in  1  sole clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  data is a valid input pixel this cycle.
- data  in  8  input pixel, raster order.
- dataout  out  8  averaged output pixel.
- validout  out  1  dataout is valid this cycle.
- out_colcount  out  10  output column of dataout, 0..NUMCOL/2-1.
- out_rowcount  out  10  output row of dataout, 0..NUMROW/2-1.
- frame_done  out  1  one-cycle pulse coincident with the last output pixel of a frame.

## Operation
- Input counters colcount (0..NUMCOL-1) and rowcount (0..NUMROW-1) advance only on valid beats.
  - colcount wraps to 0 after NUMCOL-1. rowcount increments on that wrap.
  - After col NUMCOL-1 / row NUMROW-1, both counters return to 0.
- Even-column beat: latch data into hold_px.
  - If rowcount is odd, also issue a line-buffer read at address colcount>>1.
- Odd-column beat: form hsum = hold_px + data, 9 bits, no truncation.
  - Even row: write hsum to the line buffer at address colcount>>1.
  - Odd row: form vsum = linebuf_q + hsum (10 bits), then dataout = (vsum + 2) >> 2, truncated to 8 bits. The maximum is (1020+2)>>2 = 255, so the result never overflows.
- Output counters advance after each output, wrapping at NUMCOL/2-1 and NUMROW/2-1.
- frame_done is asserted with the output at out_col NUMCOL/2-1, out_row NUMROW/2-1.
- Gaps in valid of any length, including between the two beats of a pair, must not change any result.
  - linebuf_q holds its value until the next read.
  - hold_px holds until the next even-column beat.
- A constant 0 on valid freezes all state. No outputs are generated.

## Timing
- Reset values:
  - dataout = 0, validout = 0, out_colcount = 0, out_rowcount = 0, frame_done = 0.
  - All input counters and hold_px = 0.
- Latency: validout rises exactly 1 cycle after the odd-row, odd-column input beat. dataout, out_* and frame_done are registered and aligned with it.
- The line buffer has 1-cycle synchronous read latency. The read is issued on the even beat, so linebuf_q is ready by the odd beat, which is at the earliest 1 cycle later.
- Back-to-back valid is allowed for the full frame. The maximum output rate is one pixel per 2 cycles, on odd rows only.
- Reset asserted mid-frame:
  - Counters and outputs clear immediately, asynchronously.
  - The line buffer is not cleared. This is harmless because every odd row reads only entries written by the preceding even row.
  - The first beat after reset release is treated as pixel (0,0) of a new frame.
- Parameter violation (odd or >1024): an elaboration-time error.

## Structure
- Shared pyramid package holds:
  - default NUMCOL/NUMROW constants;
  - pixel width (8);
  - counter width (10);
  - the round-average function (sum+2)>>2.
- One sub-module, pair_line_buffer:
  - simple dual-port RAM, NUMCOL/2 × 9 bits;
  - one write port and one read port, registered output, no reset.
- Everything else (counters, pair/row logic, output register) lives in downsampler2x.

## Test plan
- Constant frame: all pixels 100, continuous valid, 800×600 → exactly 120000 outputs, all 100. frame_done pulses once, with out_col 399 / out_row 299.
- Rounding, NUMCOL=8, NUMROW=4: block (1,2 / 3,4) → 3; block (0,0 / 0,1) → 0; block (0,0 / 1,1) → 1; all-255 block → 255.
- Ramp data = col + 16·row, NUMCOL=8, NUMROW=4 → outputs match the reference model, in raster order, with correct out_colcount/out_rowcount.
- Gapped valid: the same ramp with valid pseudo-random at ~30%, including a gap between pair beats → output values identical to the continuous case. Each validout occurs 1 cycle after its odd/odd input beat.
- Reset mid-frame: drop reset_n at input row 3, col 5, then send a fresh frame → outputs reset to 0 immediately. The first new output equals the average of the new frame's block (0,0), with no stale data.
- Frame wrap: two consecutive 8×4 frames with no idle cycles → the second frame's first output has out_col 0 / out_row 0. frame_done fires exactly twice.
